// File: rtl/imm_pkg.sv
// Shared immediate-format definitions for the decode slice.
// Format codes and the default datapath width live here.
package imm_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_fmt_e;

  // Reserved selects 5-7 fall back to the I format.
  function automatic imm_fmt_e fmt_norm(
    input logic [2:0] sel
  );
    return (sel > 3'd4) ? IMM_I : imm_fmt_e'(sel);
  endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction and sign extension.
// Every format carries instr[31] in bit 31 before widening.
import imm_pkg::*;

module imm_extract #(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [31:0]     instr,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] raw;
  logic        unused_opc;

  assign unused_opc = ^instr[6:0];

  always_comb begin
    raw = {{20{instr[31]}}, instr[31:20]};
    case (fmt)
      IMM_S: raw = {{20{instr[31]}},
                    instr[31:25], instr[11:7]};
      IMM_B: raw = {{20{instr[31]}}, instr[7],
                    instr[30:25], instr[11:8],
                    1'b0};
      IMM_U: raw = {instr[31:12], 12'b0};
      IMM_J: raw = {{12{instr[31]}}, instr[19:12],
                    instr[20], instr[30:21], 1'b0};
      default: raw = {{20{instr[31]}},
                      instr[31:20]};
    endcase
  end

  generate
    if (XLEN > 32) begin : g_wide
      assign imm = {{(XLEN-32){raw[31]}}, raw};
    end else begin : g_narrow
      assign imm = raw[XLEN-1:0];
    end
  endgenerate

endmodule

// File: rtl/imm_decode_stage.sv
// Immediate decode stage: 1-cycle latency with a skid slot.
// in_ready is a pure register output, isolated from out_ready.
import imm_pkg::*;

module imm_decode_stage #(
  parameter int XLEN  = XLEN_DEF,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [TAG_W-1:0] out_tag
);

  imm_fmt_e         dec_fmt;
  logic [XLEN-1:0]  dec_imm;

  logic             out_vld_q, out_vld_d;
  logic [XLEN-1:0]  out_imm_q, out_imm_d;
  imm_fmt_e         out_fmt_q, out_fmt_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  logic             skid_vld_q, skid_vld_d;
  logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
  imm_fmt_e         skid_fmt_q, skid_fmt_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

  logic             accept;
  logic             out_free;

  assign dec_fmt = fmt_norm(in_imm_sel);

  imm_extract #(
    .XLEN (XLEN)
  ) u_extract (
    .instr (in_instr),
    .fmt   (dec_fmt),
    .imm   (dec_imm)
  );

  assign in_ready  = rst | ~skid_vld_q;
  assign accept    = in_valid & ~skid_vld_q;
  assign out_free  = ~out_vld_q | out_ready;

  assign out_valid = out_vld_q;
  assign out_imm   = out_imm_q;
  assign out_fmt   = out_fmt_q;
  assign out_tag   = out_tag_q;

  always_comb begin
    out_vld_d  = out_vld_q;
    out_imm_d  = out_imm_q;
    out_fmt_d  = out_fmt_q;
    out_tag_d  = out_tag_q;
    skid_vld_d = skid_vld_q;
    skid_imm_d = skid_imm_q;
    skid_fmt_d = skid_fmt_q;
    skid_tag_d = skid_tag_q;
    if (out_free) begin
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        out_imm_d  = skid_imm_q;
        out_fmt_d  = skid_fmt_q;
        out_tag_d  = skid_tag_q;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        out_vld_d = 1'b1;
        out_imm_d = dec_imm;
        out_fmt_d = dec_fmt;
        out_tag_d = in_tag;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_vld_d = 1'b1;
      skid_imm_d = dec_imm;
      skid_fmt_d = dec_fmt;
      skid_tag_d = in_tag;
    end
    if (flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
    end
    out_imm_q  <= out_imm_d;
    out_fmt_q  <= out_fmt_d;
    out_tag_q  <= out_tag_d;
    skid_imm_q <= skid_imm_d;
    skid_fmt_q <= skid_fmt_d;
    skid_tag_q <= skid_tag_d;
  end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: directed vectors plus a
// random-stall stream against a queue-based reference.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [2:0]  in_imm_sel;
  logic [4:0]  in_tag;
  logic        out_ready;

  logic        in_ready_a, in_ready_b;
  logic        out_valid_a, out_valid_b;
  logic [31:0] out_imm_a;
  logic [63:0] out_imm_b;
  logic [2:0]  out_fmt_a, out_fmt_b;
  logic [4:0]  out_tag_a, out_tag_b;

  int checks = 0;
  int errors = 0;
  int accepted = 0;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [4:0]  tag;
  } beat_t;

  beat_t mq[$];

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .TAG_W(5)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready_a),
    .in_instr   (in_instr),
    .in_imm_sel (in_imm_sel),
    .in_tag     (in_tag),
    .out_valid  (out_valid_a),
    .out_ready  (out_ready),
    .out_imm    (out_imm_a),
    .out_fmt    (out_fmt_a),
    .out_tag    (out_tag_a)
  );

  imm_decode_stage #(.XLEN(64), .TAG_W(5)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready_b),
    .in_instr   (in_instr),
    .in_imm_sel (in_imm_sel),
    .in_tag     (in_tag),
    .out_valid  (out_valid_b),
    .out_ready  (out_ready),
    .out_imm    (out_imm_b),
    .out_fmt    (out_fmt_b),
    .out_tag    (out_tag_b)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // Field width and value from the format table, then
  // arithmetic sign extension to 64 bits.
  function automatic logic [63:0] ref_imm(
    input logic [31:0] i,
    input logic [2:0]  s
  );
    logic [63:0]        v;
    logic signed [63:0] t;
    int                 w;
    case (s)
      3'd1: begin v = 64'({i[31:25], i[11:7]}); w = 12; end
      3'd2: begin
        v = 64'({i[31], i[7], i[30:25], i[11:8], 1'b0});
        w = 13;
      end
      3'd3: begin v = 64'({i[31:12], 12'b0}); w = 32; end
      3'd4: begin
        v = 64'({i[31], i[19:12], i[20], i[30:21], 1'b0});
        w = 21;
      end
      default: begin v = 64'(i[31:20]); w = 12; end
    endcase
    t = v << (64 - w);
    return t >>> (64 - w);
  endfunction

  task automatic cyc(
    input bit          v,
    input logic [31:0] ins,
    input logic [2:0]  sel,
    input logic [4:0]  tg,
    input bit          ordy,
    input bit          fl,
    input bit          r
  );
    beat_t b;
    bit    exp_ir;
    bit    fire_in;
    bit    fire_out;
    in_valid   = v;
    in_instr   = ins;
    in_imm_sel = sel;
    in_tag     = tg;
    out_ready  = ordy;
    flush      = fl;
    rst        = r;
    @(negedge clk);
    exp_ir = r || (mq.size() < 2);
    chk("in_ready32", 64'(in_ready_a), 64'(exp_ir));
    chk("in_ready64", 64'(in_ready_b), 64'(exp_ir));
    chk("out_valid32", 64'(out_valid_a),
        64'(mq.size() != 0));
    chk("out_valid64", 64'(out_valid_b),
        64'(mq.size() != 0));
    if (mq.size() != 0 && out_valid_a && out_valid_b) begin
      chk("imm32", 64'(out_imm_a), 64'(mq[0].imm[31:0]));
      chk("imm64", out_imm_b, mq[0].imm);
      chk("fmt", 64'(out_fmt_a), 64'(mq[0].fmt));
      chk("tag", 64'(out_tag_b), 64'(mq[0].tag));
    end
    fire_in  = v && (mq.size() < 2);
    fire_out = ordy && (mq.size() != 0);
    if (r || fl) begin
      mq.delete();
    end else begin
      if (fire_out) void'(mq.pop_front());
      if (fire_in) begin
        b.imm = ref_imm(ins, sel);
        b.fmt = (sel > 3'd4) ? 3'd0 : sel;
        b.tag = tg;
        mq.push_back(b);
        accepted++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit ordy);
    cyc(1'b0, 32'h0, 3'd0, 5'd0, ordy, 1'b0, 1'b0);
  endtask

  initial begin
    in_valid = 0; in_instr = 0; in_imm_sel = 0;
    in_tag = 0; out_ready = 0; flush = 0; rst = 1;
    @(posedge clk);
    #1;
    cyc(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    chk("rst_out_valid", 64'(out_valid_a), 64'd0);
    chk("rst_in_ready", 64'(in_ready_a), 64'd1);

    // I/S/J back to back, 1-cycle latency
    cyc(1'b1, 32'hFFF00093, 3'd0, 5'd1, 1'b1, 1'b0, 1'b0);
    chk("i_valid", 64'(out_valid_a), 64'd1);
    chk("i_imm", 64'(out_imm_a), 64'hFFFFFFFF);
    cyc(1'b1, 32'hFE112E23, 3'd1, 5'd2, 1'b1, 1'b0, 1'b0);
    chk("s_imm", 64'(out_imm_a), 64'hFFFFFFFC);
    cyc(1'b1, 32'hFFDFF06F, 3'd4, 5'd3, 1'b1, 1'b0, 1'b0);
    chk("j_imm", 64'(out_imm_a), 64'hFFFFFFFC);
    chk("j_imm64", out_imm_b, 64'hFFFFFFFFFFFFFFFC);

    // U on the wide datapath, reserved select
    cyc(1'b1, 32'h800000B7, 3'd3, 5'd4, 1'b1, 1'b0, 1'b0);
    chk("u_imm64", out_imm_b, 64'hFFFFFFFF80000000);
    chk("u_fmt", 64'(out_fmt_b), 64'd3);
    cyc(1'b1, 32'h00500093, 3'd7, 5'd5, 1'b1, 1'b0, 1'b0);
    chk("sel7_imm64", out_imm_b, 64'd5);
    chk("sel7_fmt", 64'(out_fmt_b), 64'd0);
    idle(1'b1);

    // Backpressure fills output and skid
    cyc(1'b1, 32'h00100093, 3'd0, 5'd1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h00200093, 3'd0, 5'd2, 1'b0, 1'b0, 1'b0);
    chk("bp_in_ready", 64'(in_ready_a), 64'd0);
    chk("bp_head_tag", 64'(out_tag_a), 64'd1);
    idle(1'b1);
    chk("bp_second_tag", 64'(out_tag_a), 64'd2);
    chk("bp_second_valid", 64'(out_valid_a), 64'd1);
    chk("bp_ready_back", 64'(in_ready_a), 64'd1);
    idle(1'b1);
    chk("bp_empty", 64'(out_valid_a), 64'd0);

    // Flush with two held beats and a same-cycle offer
    cyc(1'b1, 32'h00300093, 3'd0, 5'd7, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h00400093, 3'd0, 5'd8, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h00500093, 3'd0, 5'd9, 1'b0, 1'b1, 1'b0);
    chk("fl_out_valid", 64'(out_valid_a), 64'd0);
    chk("fl_in_ready", 64'(in_ready_a), 64'd1);
    idle(1'b1);
    chk("fl_nothing", 64'(out_valid_a), 64'd0);

    // Reset in the middle of a stall
    cyc(1'b1, 32'h00600093, 3'd0, 5'd10, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h00700093, 3'd0, 5'd11, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h00800093, 3'd0, 5'd12, 1'b0, 1'b0, 1'b1);
    chk("rst_mid_ready", 64'(in_ready_a), 64'd1);
    chk("rst_mid_valid", 64'(out_valid_a), 64'd0);
    idle(1'b0);
    chk("post_rst_ready", 64'(in_ready_a), 64'd1);

    accepted = 0;
    for (int n = 0; n < 6000 && accepted < 1000; n++) begin
      cyc(($urandom_range(0, 9) < 7),
          $urandom,
          3'($urandom_range(0, 7)),
          5'($urandom),
          ($urandom_range(0, 9) < 6),
          1'b0, 1'b0);
    end
    chk("stream_beats", 64'(accepted), 64'd1000);
    for (int n = 0; n < 4; n++) idle(1'b1);
    chk("stream_drained", 64'(mq.size()), 64'd0);
    chk("end_out_valid", 64'(out_valid_a), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 Parameter XLEN, default 32, immediate output width; legal values 32 and 64.
REQ-002 Parameter TAG_W, default 5, width of the sideband tag carried alongside each beat (e.g. rd index).
REQ-003 The port list SHALL be, one per line, as follows.
  clk  input  1  single clock; all state updates on rising edge.
  rst  input  1  synchronous, active-high reset.
  flush  input  1  discards all held beats.
  in_valid  input  1  upstream beat present.
  in_ready  output  1  stage can accept a beat.
  in_instr  input  32  raw instruction word.
  in_imm_sel  input  3  immediate format select.
  in_tag  input  TAG_W  sideband, passed unchanged.
  out_valid  output  1  decoded beat present.
  out_ready  input  1  downstream accepts beat.
  out_imm  output  XLEN  sign-extended immediate.
  out_fmt  output  3  format actually applied.
  out_tag  output  TAG_W  sideband of the output beat.

Function
REQ-004 Formats SHALL be: 0=I {instr[31:20]}; 1=S {instr[31:25],instr[11:7]}; 2=B {instr[31],instr[7],instr[30:25],instr[11:8],0}; 3=U {instr[31:12],12'b0}; 4=J {instr[31],instr[19:12],instr[20],instr[30:21],0}.
REQ-005 Codes 5-7 SHALL decode as I; out_fmt reports 0 for them.
REQ-006 All formats SHALL be sign-extended from instr[31] to XLEN bits; U is sign-extended from bit 31 when XLEN=64.
REQ-007 A beat transfers in on in_valid && in_ready and out on out_valid && out_ready.
REQ-008 Latency SHALL be exactly 1 cycle: a beat accepted in cycle N appears on out_* in cycle N+1 when the output register is empty or draining.
REQ-009 The stage SHALL hold at most 2 beats: an output register and a one-entry skid register.
REQ-010 in_ready SHALL equal !skid_valid and be driven from a register only, with no combinational path from out_ready.
REQ-011 Stall: if the output is full and not drained while a beat is accepted, the decoded beat SHALL go into skid.
REQ-012 Drain: when the output drains and skid is valid, skid SHALL move to the output in the same edge, with no bubble.
REQ-013 Full drain: with skid empty, a simultaneous output drain and input accept SHALL load the output register directly; throughput is 1 beat/cycle.
REQ-014 Beat order SHALL be preserved; no beat is duplicated or dropped except by flush or rst.
REQ-015 out_* SHALL stay stable while out_valid && !out_ready.
REQ-016 Flush SHALL clear out_valid and skid_valid at the next edge, override any same-cycle accept, and leave in_ready=1 the cycle after.
REQ-017 Data registers need no reset; only valid bits are reset.

Reset
REQ-018 At rst=1 on an edge, out_valid=0, skid empty, and in_ready=1 the following cycle.
REQ-019 rst mid-operation SHALL discard held beats; rst takes priority over flush and handshakes.
REQ-020 in_ready SHALL read 1 while rst is asserted.

Structure
REQ-021 Package imm_pkg SHALL hold the imm_fmt_e enum (IMM_I..IMM_J, 3 bits) and the XLEN default constant.
REQ-022 The format extraction and sign extension SHALL be a combinational sub-module imm_extract (instr, fmt -> XLEN imm), instantiated once at the input side.
REQ-023 Target size: 120-250 RTL lines.

Verification
REQ-024 I/S/J: in 0xFFF00093 sel0, then 0xFE112E23 sel1, then 0xFFDFF06F sel4, with out_ready=1 -> out_imm 0xFFFFFFFF, 0xFFFFFFFC, 0xFFFFFFFC in consecutive cycles, 1-cycle latency.
REQ-025 XLEN=64 U: in 0x800000B7 sel3 -> out_imm 0xFFFFFFFF80000000, out_fmt 3; sel7 on 0x00500093 -> imm 5, out_fmt 0.
REQ-026 Backpressure: out_ready=0 with beats tag 1, 2 -> in_ready=0 after the 2nd beat; release -> tags 1, 2 in order on back-to-back cycles, then in_ready=1.
REQ-027 Flush with 2 beats held plus in_valid=1 same cycle -> next cycle out_valid=0, in_ready=1, and no beat emerges.
REQ-028 rst asserted mid-stall for 1 cycle -> out_valid=0 and in_ready=1; a random-stall stream of 1000 beats afterward matches the reference model in order.
